// File: rtl/alu_mdu.sv
// alu_mdu: RV32 execute unit. Base ALU ops, branch compare and RV32M behind one
// valid/ready interface. Non-divide ops register their result at the accept edge.
// Divides use an iterative radix-2 restoring divider.
// Optional feature macro: ALU_MDU_MULDIV_EN (multiplier + divider, ops 16-23).
// Without it, ops 16-23 complete in one cycle as illegal.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_in1,
    input  logic [XLEN-1:0] i_in2,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out,
    output logic            o_zero,
    output logic            o_illegal
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
`ifdef ALU_MDU_MULDIV_EN
    localparam logic [1:0] ST_DIV_BUSY = 2'd1;
`endif
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [1:0]      r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out;
    logic            r_zero;
    logic            r_illegal;

    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_zero;
    logic            w_illegal;

    assign o_in_ready  = (r_state == ST_IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_shamt     = i_in2[SHW-1:0];
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;
    assign o_zero      = r_zero;
    assign o_illegal   = r_illegal;

`ifdef ALU_MDU_MULDIV_EN
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic              w_ma_sgn;
    logic              w_mb_sgn;
    logic              w_div_signed;
    logic              w_div_ovf;
    logic              w_start_div;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;

    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvsr;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_is_rem;
    logic [SHW:0]      r_cnt;

    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_div_fin;

    // Sign-/zero-extend to 2*XLEN so one truncated product serves all four MUL variants.
    assign w_ma_sgn = (i_op == 5'd17) || (i_op == 5'd18);
    assign w_mb_sgn = (i_op == 5'd17);
    assign w_ma     = {{XLEN{w_ma_sgn & i_in1[XLEN-1]}}, i_in1};
    assign w_mb     = {{XLEN{w_mb_sgn & i_in2[XLEN-1]}}, i_in2};
    assign w_prod   = w_ma * w_mb;

    assign w_div_signed = !i_op[0];
    assign w_div_ovf    = w_div_signed && (i_in1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_in2);
    assign w_mag1       = (w_div_signed && i_in1[XLEN-1]) ? -i_in1 : i_in1;
    assign w_mag2       = (w_div_signed && i_in2[XLEN-1]) ? -i_in2 : i_in2;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dvsr};
    assign w_rem_nx = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    assign w_div_fin = r_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                                : (r_neg_q ? -w_quo_nx : w_quo_nx);
`endif

    // Single-cycle result for every op that does not need the iterative divider.
    always_comb begin
        w_res     = '0;
        w_zero    = 1'b0;
        w_illegal = 1'b0;
`ifdef ALU_MDU_MULDIV_EN
        w_start_div = 1'b0;
`endif
        case (i_op)
            5'd0:  w_res = i_in1 + i_in2;
            5'd1:  w_res = i_in1 - i_in2;
            5'd2:  w_res = i_in1 << w_shamt;
            5'd3:  w_res = {{(XLEN-1){1'b0}}, $signed(i_in1) < $signed(i_in2)};
            5'd4:  w_res = {{(XLEN-1){1'b0}}, i_in1 < i_in2};
            5'd5:  w_res = i_in1 ^ i_in2;
            5'd6:  w_res = i_in1 >> w_shamt;
            5'd7:  w_res = $unsigned($signed(i_in1) >>> w_shamt);
            5'd8:  w_res = i_in1 | i_in2;
            5'd9:  w_res = i_in1 & i_in2;
            5'd10: w_zero = (i_in1 == i_in2);
            5'd11: w_zero = (i_in1 != i_in2);
            5'd12: w_zero = ($signed(i_in1) < $signed(i_in2));
            5'd13: w_zero = ($signed(i_in1) >= $signed(i_in2));
            5'd14: w_zero = (i_in1 < i_in2);
            5'd15: w_zero = (i_in1 >= i_in2);
`ifdef ALU_MDU_MULDIV_EN
            5'd16: w_res = w_prod[XLEN-1:0];
            5'd17, 5'd18, 5'd19: w_res = w_prod[2*XLEN-1:XLEN];
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (i_in2 == '0) begin
                    w_res = i_op[1] ? i_in1 : '1;
                end else if (w_div_ovf) begin
                    w_res = i_op[1] ? '0 : i_in1;
                end else begin
                    w_start_div = 1'b1;
                end
            end
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // Control FSM and output registers; flush kills everything including a same-cycle accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (i_flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef ALU_MDU_MULDIV_EN
                        if (w_start_div) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_DIV_BUSY;
                        end else
`endif
                        begin
                            r_out       <= w_res;
                            r_zero      <= w_zero;
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MDU_MULDIV_EN
                ST_DIV_BUSY: begin
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_out       <= w_div_fin;
                        r_zero      <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
`endif
                ST_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_MDU_MULDIV_EN
    // Divider datapath: load magnitudes on a normal divide accept, then one step per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && w_accept && w_start_div) begin
            r_quo    <= w_mag1;
            r_rem    <= '0;
            r_dvsr   <= w_mag2;
            r_neg_q  <= w_div_signed && (i_in1[XLEN-1] ^ i_in2[XLEN-1]);
            r_neg_r  <= w_div_signed && i_in1[XLEN-1];
            r_is_rem <= i_op[1];
            r_cnt    <= (SHW+1)'(XLEN);
        end else if ((r_state == ST_DIV_BUSY) && (r_cnt != '0)) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - (SHW+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed test-plan cases plus randomized ops checked
// against an arithmetic reference model. Follows ALU_MDU_MULDIV_EN like the RTL.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_op       (op),
        .i_in1      (in1),
        .i_in2      (in2),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out      (out),
        .o_zero     (zero),
        .o_illegal  (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: result, branch flag, illegal flag and edges from issue to visible result.
    function automatic void ref_model(input logic [4:0] f_op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic z, output logic ill, output int lat);
        int sa;
        int sb;
        longint prod;
        longint unsigned pu;
        logic [4:0] sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        r = 32'd0;
        z = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (f_op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << sh;
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> sh;
            5'd7:  r = sa >>> sh;
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: z = (a == b);
            5'd11: z = (a != b);
            5'd12: z = (sa < sb);
            5'd13: z = (sa >= sb);
            5'd14: z = (a < b);
            5'd15: z = (a >= b);
`ifdef ALU_MDU_MULDIV_EN
            5'd16: begin prod = longint'(sa) * longint'(sb); r = prod[31:0]; end
            5'd17: begin prod = longint'(sa) * longint'(sb); r = prod[63:32]; end
            5'd18: begin prod = longint'(sa) * longint'({32'd0, b}); r = prod[63:32]; end
            5'd19: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            5'd20: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin r = sa / sb; lat = 33; end
            end
            5'd21: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else begin r = a / b; lat = 33; end
            end
            5'd22: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin r = sa % sb; lat = 33; end
            end
            5'd23: begin
                if (b == 32'd0) r = a;
                else begin r = a % b; lat = 33; end
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one op at a negedge, wait (bounded) for the result and compare everything.
    task automatic do_op(input logic [4:0] f_op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got);
        logic [31:0] er;
        logic ez;
        logic ei;
        int elat;
        int lat;
        int waitc;
        logic busy_ok;
        ref_model(f_op, a, b, er, ez, ei, elat);
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = f_op;
        in1 = a;
        in2 = b;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 100);
        check($sformatf("latency op%0d", f_op), lat, elat);
        check($sformatf("out op%0d a=%08h b=%08h", f_op, a, b), out, er);
        check($sformatf("zero op%0d", f_op), {31'd0, zero}, {31'd0, ez});
        check($sformatf("illegal op%0d", f_op), {31'd0, illegal}, {31'd0, ei});
        if (elat > 1) check("in_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
        got = out;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        int seen;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        op = 5'd0;
        in1 = 32'd0;
        in2 = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out", out, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        do_op(5'd7, 32'h80000000, 32'h24, g);
        check("sra_shamt4", g, 32'hF8000000);
        do_op(5'd15, 32'd1, 32'hFFFFFFFF, g);
        check("bgeu_out_zero", g, 32'd0);
        check("bgeu_not_taken", {31'd0, zero}, 32'd0);
`ifdef ALU_MDU_MULDIV_EN
        do_op(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, g);
        check("mulh_m1", g, 32'd0);
        do_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, g);
        check("mulhu_m1", g, 32'hFFFFFFFE);
        do_op(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, g);
        check("mul_m1", g, 32'd1);
        do_op(5'd20, 32'hFFFFFFF9, 32'd2, g);
        check("div_m7_2", g, 32'hFFFFFFFD);
        do_op(5'd22, 32'hFFFFFFF9, 32'd2, g);
        check("rem_m7_2", g, 32'hFFFFFFFF);
        do_op(5'd21, 32'd123, 32'd0, g);
        check("divu_by0", g, 32'hFFFFFFFF);
        do_op(5'd22, 32'h1234, 32'd0, g);
        check("rem_by0", g, 32'h1234);
        do_op(5'd20, 32'h80000000, 32'hFFFFFFFF, g);
        check("div_ovf", g, 32'h80000000);
`else
        do_op(5'd20, 32'd9, 32'd3, g);
        check("op20_illegal", {31'd0, illegal}, 32'd1);
`endif

        // Backpressure: ADD result must hold while out_ready is low.
        in_valid = 1'b1; op = 5'd0; in1 = 32'd100; in2 = 32'd23;
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("hold add valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out stable", out, 32'd123);
            check("hold in_ready low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = 5'd1; in1 = 32'd50; in2 = 32'd8;
        #1 check("release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("release next valid", {31'd0, out_valid}, 32'd1);
        check("release next out", out, 32'd42);

        // Flush beats a same-cycle accept.
        in_valid = 1'b1; op = 5'd0; in1 = 32'd1; in2 = 32'd2; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_accept valid", {31'd0, out_valid}, 32'd0);
        check("flush_accept in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_MDU_MULDIV_EN
        // Flush in the middle of a divide.
        in_valid = 1'b1; op = 5'd20; in1 = 32'd1000; in2 = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_div valid", {31'd0, out_valid}, 32'd0);
        check("flush_div in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_div no result", seen, 32'd0);
        do_op(5'd21, 32'd1000, 32'd7, g);

        // Reset in the middle of a divide.
        in_valid = 1'b1; op = 5'd20; in1 = 32'd1000; in2 = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
`else
        // Reset with a result pending.
        in_valid = 1'b1; op = 5'd0; in1 = 32'd5; in2 = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        seen = 0;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid out", out, 32'd0);
        check("rst_mid zero", {31'd0, zero}, 32'd0);
        check("rst_mid illegal", {31'd0, illegal}, 32'd0);
        check("rst_mid in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;

        for (int n = 0; n < 200; n++) begin
            logic [4:0] rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 5'($urandom_range(0, 31));
            ra = pick_operand();
            rb = pick_operand();
            do_op(rop, ra, rb, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked execute unit for the RV32 core: the base integer ALU and branch comparator plus the RV32M multiply/divide operations behind one valid/ready interface. Base ops, compares and multiplies produce a registered result one cycle after acceptance. Divide/remainder run on an iterative radix-2 divider. Sits between the ID/EX pipeline register and the EX/MEM register; the core stalls issue while `in_ready` is low.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width (derived; do not override).

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill in-flight op and pending result (branch mispredict).
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept.
- `op` in 5: 0–15 base ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU); 16–23 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; 24–31 reserved.
- `in1`, `in2` in XLEN: operands.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out` out XLEN: arithmetic result; 0 for branch ops.
- `zero` out 1: branch-taken flag; 0 for non-branch ops.
- `illegal` out 1: op was reserved/unsupported; qualified by `out_valid`.

## Operation
- FSM states: IDLE, DIV_BUSY, HOLD.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`. Accept = `in_valid && in_ready`.
- IDLE accept, op 0–19 or 24–31: compute combinationally; register `out`/`zero`/`illegal`; set `out_valid`; stay IDLE.
- Shifts use `in2[SHW-1:0]`. SRA is arithmetic. SLT/SLTU return 0/1, zero-extended.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned products.
- IDLE accept, op 20–23 (DIV, DIVU, REM, REMU):
  - Divisor = 0: quotient = all ones, remainder = dividend. Completes like a base op.
  - Signed overflow (DIV/REM with in1 = 100…0 and in2 = −1): quotient = in1, remainder = 0. Completes like a base op.
  - Otherwise: latch the magnitudes and sign fixups, load counter = XLEN, go to DIV_BUSY.
- DIV_BUSY: one restoring shift-subtract step per cycle; decrement counter. After the step at counter = 1, apply signs: quotient negated if operand signs differ, remainder takes the dividend's sign. Register the result, set `out_valid`, go to HOLD.
- HOLD: wait for `out_ready`; on handshake clear `out_valid` and go to IDLE.
- Output stability: while `out_valid && !out_ready`, `out`, `zero` and `illegal` hold stable.
- Back-to-back:
  - Result handshake and new accept in the same IDLE cycle are allowed; the new result replaces the old.
  - No new op is accepted in DIV_BUSY or HOLD.
- Flush: next cycle, `out_valid` = 0 and state = IDLE; the divider is abandoned. `flush` dominates a simultaneous accept, and that op is discarded.
- Reset values: `out_valid` = 0, `out` = 0, `zero` = 0, `illegal` = 0, state = IDLE, counter = 0. `in_ready` = 1 in the first cycle after reset.

## Timing
- Accept at edge N: base/branch/MUL*/special-divide results visible with `out_valid` = 1 after edge N+1 (latency 1).
- Normal divide: `out_valid` rises after edge N+XLEN+1 (33 for XLEN = 32). `in_ready` stays low from edge N+1 until the result handshake.
- Throughput: one non-divide op per cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`. There is no other input-to-output combinational path.

## Configuration
- `ALU_MDU_MULDIV_EN` defined: ops 16–23 behave as above; the multiplier and divider are instantiated.
- Undefined: no multiplier, divider or DIV_BUSY state. Ops 16–23 complete in 1 cycle with `out` = 0, `zero` = 0, `illegal` = 1, like reserved ops 24–31.

## Test plan
- Base ops, XLEN = 32:
  - SRA in1 = 0x80000000, in2 = 0x24 → out = 0xF8000000 (shamt 4).
  - BGEU in1 = 1, in2 = 0xFFFFFFFF → zero = 0, out = 0.
  - All 1-cycle latency.
- MULH in1 = 0xFFFFFFFF, in2 = 0xFFFFFFFF → out = 0. MULHU same operands → out = 0xFFFFFFFE. MUL → 0x00000001.
- DIV in1 = −7, in2 = 2:
  - out = 0xFFFFFFFD after 33 cycles; `in_ready` low throughout.
  - REM same operands → 0xFFFFFFFF.
- Divide corner cases, 1-cycle latency:
  - DIVU by 0 → 0xFFFFFFFF.
  - REM by 0 → in1.
  - DIV 0x80000000 / −1 → 0x80000000.
- Handshake: hold `out_ready` = 0 for 5 cycles after an ADD → `out` stable, `in_ready` = 0. Release → next op accepted in the same cycle.
- Mid-op disruption:
  - `flush` at cycle 10 of a DIV → `out_valid` never rises, `in_ready` = 1 next cycle.
  - `rst` mid-divide → all outputs reset values.
  - Macro undefined, op 20 → `illegal` = 1 after 1 cycle.
